// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequences fetch-buffer slot overrides for multi-slot
// instructions (CALL, RET, RTI, LDM) and hardware interrupt entry, and
// holds the PC while stack micro-instructions are injected.
// Optional feature macro: FETCH_SEQ_INT_EN enables the interrupt entry
// sequence, the pending flag, pc_load_vec and int_ack. Without it int_req
// is ignored and pc_load_vec/int_ack stay 0.
// All outputs are registered; decode happens on the edge that enters the
// sequence, so the first override slot appears one cycle after the trigger.

module fetch_sequencer #(
    parameter int unsigned          OPCODE_W = 5,
    parameter logic [OPCODE_W-1:0]  CALL_OP  = 5'b11000,
    parameter logic [OPCODE_W-1:0]  RET_OP   = 5'b11001,
    parameter logic [OPCODE_W-1:0]  RTI_OP   = 5'b11010,
    parameter logic [OPCODE_W-1:0]  LDM_OP   = 5'b01100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    input  logic [OPCODE_W-1:0]  instr_opcode,
    input  logic                 int_req,
    output logic [2:0]           slot_sel,
    output logic                 pc_hold,
    output logic                 pc_load_vec,
    output logic                 int_ack,
    output logic                 busy
);

    // Fetch-buffer override encodings
    localparam logic [2:0] SLOT_PASS       = 3'd0;
    localparam logic [2:0] SLOT_NOP        = 3'd1;
    localparam logic [2:0] SLOT_NOP_IMM    = 3'd2;
    localparam logic [2:0] SLOT_PUSH_PC_HI = 3'd3;
    localparam logic [2:0] SLOT_PUSH_PC_LO = 3'd4;
    localparam logic [2:0] SLOT_PUSH_FLAGS = 3'd5;
    localparam logic [2:0] SLOT_POP_PC_LO  = 3'd6;
    localparam logic [2:0] SLOT_POP_FLAGS  = 3'd7;

    // One state per override slot; each state's outputs are the slot it names.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CALL      = 4'd1,
        ST_RET_POP   = 4'd2,
        ST_RET_NOP   = 4'd3,
        ST_RTI_POPPC = 4'd4,
        ST_RTI_POPFL = 4'd5,
        ST_RTI_NOP   = 4'd6,
        ST_LDM       = 4'd7
`ifdef FETCH_SEQ_INT_EN
        ,
        ST_INT_FLAGS = 4'd8,
        ST_INT_PCL   = 4'd9,
        ST_INT_PCH   = 4'd10,
        ST_INT_NOP   = 4'd11
`endif
    } state_t;

    // Registered output bundle derived from a state
    typedef struct packed {
        logic [2:0] slot;
        logic       hold;
        logic       vec;
        logic       ack;
        logic       busy;
    } outs_t;

    // Map a state to the outputs presented during that state's cycle
    function automatic outs_t state_outs(input state_t st);
        outs_t o;
        o = '{slot: SLOT_PASS, hold: 1'b0, vec: 1'b0, ack: 1'b0, busy: 1'b1};
        case (st)
            ST_IDLE:      o.busy = 1'b0;
            ST_CALL:      begin o.slot = SLOT_PUSH_PC_HI; o.hold = 1'b1; end
            ST_RET_POP:   begin o.slot = SLOT_POP_PC_LO;  o.hold = 1'b1; end
            ST_RET_NOP:   begin o.slot = SLOT_NOP;        o.hold = 1'b1; end
            ST_RTI_POPPC: begin o.slot = SLOT_POP_PC_LO;  o.hold = 1'b1; end
            ST_RTI_POPFL: begin o.slot = SLOT_POP_FLAGS;  o.hold = 1'b1; end
            ST_RTI_NOP:   begin o.slot = SLOT_NOP;        o.hold = 1'b1; end
            // Immediate word must still be fetched, so the PC keeps moving
            ST_LDM:       o.slot = SLOT_NOP_IMM;
`ifdef FETCH_SEQ_INT_EN
            ST_INT_FLAGS: begin o.slot = SLOT_PUSH_FLAGS; o.hold = 1'b1; end
            ST_INT_PCL:   begin o.slot = SLOT_PUSH_PC_LO; o.hold = 1'b1; end
            ST_INT_PCH:   begin o.slot = SLOT_PUSH_PC_HI; o.hold = 1'b1; end
            // PC is redirected to the vector here, so it is not held
            ST_INT_NOP:   begin o.slot = SLOT_NOP; o.vec = 1'b1; o.ack = 1'b1; end
`endif
            default:      o = '{slot: SLOT_PASS, hold: 1'b0, vec: 1'b0, ack: 1'b0, busy: 1'b0};
        endcase
        return o;
    endfunction

    // Decode an instruction trigger into the first state of its sequence
    function automatic state_t decode_instr(input logic valid, input logic [OPCODE_W-1:0] op);
        state_t st;
        st = ST_IDLE;
        if (valid) begin
            if (op == CALL_OP) begin
                st = ST_CALL;
            end else if (op == RET_OP) begin
                st = ST_RET_POP;
            end else if (op == RTI_OP) begin
                st = ST_RTI_POPPC;
            end else if (op == LDM_OP) begin
                st = ST_LDM;
            end else begin
                st = ST_IDLE;
            end
        end else begin
            st = ST_IDLE;
        end
        return st;
    endfunction

    state_t state_r;
    state_t state_next_s;
    logic   free_s;       // current cycle is IDLE or the last slot of a sequence
    outs_t  outs_next_s;

`ifdef FETCH_SEQ_INT_EN
    logic pending_r;
    logic pending_next_s;
    logic int_go_s;

    // Interrupt wants service; a pending flag about to be cleared by the
    // completing entry must not launch a second entry
    always_comb begin
        int_go_s = 1'b0;
        if (state_r == ST_INT_NOP) begin
            int_go_s = int_req;
        end else begin
            int_go_s = int_req | pending_r;
        end
    end

    // Pending accumulates requests (merged, no count) until entry completes
    always_comb begin
        pending_next_s = pending_r;
        if (state_r == ST_INT_NOP) begin
            pending_next_s = 1'b0;
        end else begin
            pending_next_s = pending_r | int_req;
        end
    end
`else
    logic unused_int_req_s;
    assign unused_int_req_s = int_req;
`endif

    // Next-state logic: chain through multi-slot sequences, decode new
    // triggers on IDLE or on the last slot so sequences can run back-to-back
    always_comb begin
        state_next_s = state_r;
        free_s       = 1'b0;
        case (state_r)
            ST_IDLE:      free_s = 1'b1;
            ST_CALL:      free_s = 1'b1;
            ST_RET_POP:   state_next_s = ST_RET_NOP;
            ST_RET_NOP:   free_s = 1'b1;
            ST_RTI_POPPC: state_next_s = ST_RTI_POPFL;
            ST_RTI_POPFL: state_next_s = ST_RTI_NOP;
            ST_RTI_NOP:   free_s = 1'b1;
            ST_LDM:       free_s = 1'b1;
`ifdef FETCH_SEQ_INT_EN
            ST_INT_FLAGS: state_next_s = ST_INT_PCL;
            ST_INT_PCL:   state_next_s = ST_INT_PCH;
            ST_INT_PCH:   state_next_s = ST_INT_NOP;
            ST_INT_NOP:   free_s = 1'b1;
`endif
            default:      state_next_s = ST_IDLE;
        endcase

        if (free_s) begin
            state_next_s = decode_instr(instr_valid, instr_opcode);
`ifdef FETCH_SEQ_INT_EN
            // Instructions win; the interrupt waits in pending
            if ((state_next_s == ST_IDLE) && int_go_s) begin
                state_next_s = ST_INT_FLAGS;
            end else begin
                state_next_s = state_next_s;
            end
`endif
        end else begin
            state_next_s = state_next_s;
        end
    end

    // Outputs for the coming cycle are decoded from the next state
    always_comb begin
        outs_next_s = state_outs(state_next_s);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            slot_sel <= SLOT_PASS;
            pc_hold  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            slot_sel <= outs_next_s.slot;
            pc_hold  <= outs_next_s.hold;
            busy     <= outs_next_s.busy;
        end
    end

`ifdef FETCH_SEQ_INT_EN
    // Interrupt bookkeeping registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r   <= 1'b0;
            pc_load_vec <= 1'b0;
            int_ack     <= 1'b0;
        end else begin
            pending_r   <= pending_next_s;
            pc_load_vec <= outs_next_s.vec;
            int_ack     <= outs_next_s.ack;
        end
    end
`else
    logic unused_outs_s;
    assign unused_outs_s = outs_next_s.vec | outs_next_s.ack;
    assign pc_load_vec   = 1'b0;
    assign int_ack       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer. Expected output vectors are
// hand-computed; interrupt expectations follow FETCH_SEQ_INT_EN.

module tb_fetch_sequencer;

    localparam logic [4:0] OP_CALL  = 5'b11000;
    localparam logic [4:0] OP_RET   = 5'b11001;
    localparam logic [4:0] OP_RTI   = 5'b11010;
    localparam logic [4:0] OP_LDM   = 5'b01100;
    localparam logic [4:0] OP_OTHER = 5'b00001;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic [4:0] instr_opcode;
    logic       int_req;
    logic [2:0] slot_sel;
    logic       pc_hold;
    logic       pc_load_vec;
    logic       int_ack;
    logic       busy;

    int n_pass;
    int n_total;

    fetch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_opcode (instr_opcode),
        .int_req      (int_req),
        .slot_sel     (slot_sel),
        .pc_hold      (pc_hold),
        .pc_load_vec  (pc_load_vec),
        .int_ack      (int_ack),
        .busy         (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack {slot_sel, pc_hold, pc_load_vec, int_ack, busy}
    function automatic logic [6:0] ev(input logic [2:0] s, input logic h,
                                      input logic v, input logic a, input logic b);
        return {s, h, v, a, b};
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {slot_sel, pc_hold, pc_load_vec, int_ack, busy};
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got slot/hold/vec/ack/busy=%b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs set before the call are sampled on it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        rst          = 1'b1;
        instr_valid  = 1'b1;
        instr_opcode = OP_CALL;
        int_req      = 1'b1;

        // Reset with CALL and int_req present
        tick(); check("rst_1", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick(); check("rst_2", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b0; instr_valid = 1'b0; int_req = 1'b0;
        tick(); check("post_rst_1", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick(); check("post_rst_2", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // CALL
        instr_valid = 1'b1; instr_opcode = OP_CALL;
        tick(); check("call_k1", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1));
        instr_valid = 1'b0;
        tick(); check("call_k2", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // RTI
        instr_valid = 1'b1; instr_opcode = OP_RTI;
        tick(); check("rti_k1", ev(3'd6, 1'b1, 1'b0, 1'b0, 1'b1));
        instr_valid = 1'b0;
        tick(); check("rti_k2", ev(3'd7, 1'b1, 1'b0, 1'b0, 1'b1));
        tick(); check("rti_k3", ev(3'd1, 1'b1, 1'b0, 1'b0, 1'b1));
        tick(); check("rti_k4", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Non-trigger opcode and invalid CALL
        instr_valid = 1'b1; instr_opcode = OP_OTHER;
        tick(); check("other_op", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        instr_valid = 1'b0; instr_opcode = OP_CALL;
        tick(); check("invalid_call", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // LDM then RET back-to-back
        instr_valid = 1'b1; instr_opcode = OP_LDM;
        tick(); check("ldm_k1", ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b1));
        instr_opcode = OP_RET;
        tick(); check("ret_k1", ev(3'd6, 1'b1, 1'b0, 1'b0, 1'b1));
        instr_valid = 1'b0;
        tick(); check("ret_k2", ev(3'd1, 1'b1, 1'b0, 1'b0, 1'b1));
        tick(); check("ret_k3", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Interrupt pulse during RTI, second pulse during entry merges
        instr_valid = 1'b1; instr_opcode = OP_RTI;
        tick(); check("irti_k1", ev(3'd6, 1'b1, 1'b0, 1'b0, 1'b1));
        instr_valid = 1'b0;
        tick(); check("irti_k2", ev(3'd7, 1'b1, 1'b0, 1'b0, 1'b1));
        int_req = 1'b1;
        tick(); check("irti_k3", ev(3'd1, 1'b1, 1'b0, 1'b0, 1'b1));
        int_req = 1'b0;
`ifdef FETCH_SEQ_INT_EN
        tick(); check("int_flags", ev(3'd5, 1'b1, 1'b0, 1'b0, 1'b1));
        tick(); check("int_pcl",   ev(3'd4, 1'b1, 1'b0, 1'b0, 1'b1));
        int_req = 1'b1;
        tick(); check("int_pch",   ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1));
        int_req = 1'b0;
        tick(); check("int_nop",   ev(3'd1, 1'b0, 1'b1, 1'b1, 1'b1));
        tick(); check("int_done",  ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick(); check("int_single",ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
`else
        for (int i = 0; i < 6; i++) begin
            tick(); check("noint_idle", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
`endif

        // Reset during PUSH_PC_LOW: request is dropped
        int_req = 1'b1;
`ifdef FETCH_SEQ_INT_EN
        tick(); check("rint_flags", ev(3'd5, 1'b1, 1'b0, 1'b0, 1'b1));
        int_req = 1'b0;
        tick(); check("rint_pcl",   ev(3'd4, 1'b1, 1'b0, 1'b0, 1'b1));
`else
        tick(); check("rint_ign_1", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        int_req = 1'b0;
        tick(); check("rint_ign_2", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
        rst = 1'b1;
        tick(); check("rint_rst", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(); check("rint_no_ack", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end

        // CALL coinciding with int_req: interrupt follows immediately
        instr_valid = 1'b1; instr_opcode = OP_CALL; int_req = 1'b1;
        tick(); check("co_call", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1));
        instr_valid = 1'b0; int_req = 1'b0;
`ifdef FETCH_SEQ_INT_EN
        tick(); check("co_flags", ev(3'd5, 1'b1, 1'b0, 1'b0, 1'b1));
        tick(); check("co_pcl",   ev(3'd4, 1'b1, 1'b0, 1'b0, 1'b1));
        tick(); check("co_pch",   ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1));
        tick(); check("co_nop",   ev(3'd1, 1'b0, 1'b1, 1'b1, 1'b1));
        tick(); check("co_done",  ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
`else
        for (int i = 0; i < 5; i++) begin
            tick(); check("co_noint", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
